matmul_tile_seq: RTL and testbench
==================================

Name: matmul_tile_seq

Overview:
- Hardware sequencer that drives one `matrix_multiplication` instance (4x4 tile engine) through a tiled (M*4)x(K*4) by (K*4)x(N*4) product.
- Accepts one job descriptor per valid/ready handshake, holding base addresses, tile counts and the int8/fp8 mode.
- For every output tile it generates tile addresses, `pe_resetn`, `start` and `is_fp8`, and follows the engine's `done`.
- Replaces bench-driven start/done stimulus with a reusable controller that sits between the host/CSR layer and the engine.

Parameters:
- ADDR_W, 10, width of matrix RAM word addresses.
- STRIDE_W, 8, width of engine stride ports.
- DIM_W, 4, width of tile-count fields; up to 15 tiles per dimension.
- TILE, 4, RAM words per 4x4 tile.
- CLR_CYCLES, 2, cycles `mm_pe_resetn` is held low before each output tile.

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous active-low reset.
- job_valid  in  1  descriptor valid.
- job_ready  out  1  sequencer can accept a descriptor.
- job_base_a / job_base_b / job_base_c  in  ADDR_W each  tile-packed matrix base addresses.
- job_m / job_n / job_k  in  DIM_W each  tile counts.
- job_is_fp8  in  1  0=int8, 1=fp8.
- busy  out  1  job in progress.
- job_done  out  1  one-cycle pulse at job end.
- job_err  out  1  sticky until the next accept; set when any dimension is 0.
- tiles_done  out  2*DIM_W  completed output tiles in the current job.
- mm_addr_a / mm_addr_b / mm_addr_c  out  ADDR_W each  engine addresses.
- mm_stride_a / mm_stride_b / mm_stride_c  out  STRIDE_W each  constant 1.
- mm_is_fp8  out  1  registered mode.
- mm_pe_resetn  out  1  engine PE clear, active low.
- mm_start  out  1  engine start.
- mm_done  in  1  engine done.

Behaviour:
- Reset: asynchronous, forces state IDLE.
  - job_ready=1; busy=0; job_done=0; job_err=0; tiles_done=0.
  - mm_start=0; mm_pe_resetn=0; mm_is_fp8=0; all mm_addr=0; strides=1.
  - A reset mid-job abandons the job; no job_done is produced.
- Accept: job_ready=1 only in IDLE. A job is accepted when job_valid&&job_ready on a rising edge; all fields latch; job_err clears.
- Zero dimension: if job_m, job_n or job_k is 0, go to FIN; job_err=1; no mm_start is issued.
- Tile layout (word addresses):
  - A(i,k) = base_a + (i*K + k)*TILE
  - B(k,j) = base_b + (j*K + k)*TILE
  - C(i,j) = base_c + (i*N + j)*TILE
  - Computed with running adders, no multipliers; wrap modulo 2^ADDR_W with no error.
- Loop order: i outer, j middle, k inner.
- States:
  - IDLE -> CLR on accept.
  - CLR: mm_pe_resetn=0 for CLR_CYCLES cycles, then RUN. Entered once per (i,j); PEs accumulate across k.
  - RUN: mm_start=1 with addresses stable. Hold until mm_done=1 is sampled, then go to DRAIN.
  - DRAIN: mm_start=0. Wait until mm_done=0, with a minimum of 1 cycle, then go to NEXT.
  - NEXT (1 cycle):
    - k<K-1: k++, go to RUN.
    - k=K-1: tiles_done++; if (i,j) is not the last tile, advance j (wrapping into i), k=0, go to CLR; otherwise go to FIN.
  - FIN: job_done=1 for 1 cycle, busy=0, go to IDLE. job_ready rises the cycle after FIN.
- busy=1 in every state except IDLE and FIN.
- mm_pe_resetn=1 outside CLR after the first accept.
- mm_done is ignored outside RUN and DRAIN. mm_done already high on entering RUN completes that pass immediately (same engine semantics as a level done).
- mm_addr_c is valid for the whole k-loop. Partial C writes are overwritten by the k=K-1 pass.
- job_valid while busy is not accepted; the descriptor must be held.
- tiles_done holds its final value until the next accept.

Test Plan:
1. Single tile: M=N=K=1, bases 0/0/0, int8, engine model asserts done 20 cycles after start -> one CLR (2 cycles), one start pulse, addresses 0/0/0, tiles_done=1, job_done 1 cycle after DRAIN exits, job_err=0.
2. 2x2x2 fp8: bases A=0x000, B=0x040, C=0x080 -> 8 start pulses, 4 CLR phases. Sequence (addr_a, addr_b, addr_c): (0,0x40,0x80), (4,0x44,0x80), (0,0x48,0x84), (4,0x4C,0x84), (8,0x40,0x88), (0xC,0x44,0x88), (8,0x48,0x8C), (0xC,0x4C,0x8C). mm_is_fp8=1 throughout; tiles_done ends at 4.
3. Sticky done: engine holds done high 5 cycles after each pass -> no new start until done falls; start never overlaps a high done.
4. Zero dimension: job_k=0 -> no mm_start, job_err=1, job_done pulse within 3 cycles of accept, job_ready returns.
5. Reset mid-job: assert resetn=0 during the RUN of pass 3 of test 2 -> all outputs at reset values immediately, no job_done. A new 1x1x1 job after release completes normally.
6. Back-to-back: job_valid held with a second descriptor during job 1 -> accepted exactly one cycle after job 1's job_done; its fields are unaffected by changes made while it was unaccepted.

Source files
------------

// File: rtl/matmul_tile_seq.sv
// Tile sequencer for a 4x4 matrix_multiplication engine: walks a tiled (M*4)x(K*4) by (K*4)x(N*4)
// product, issuing per-pass tile addresses, PE clear, start and mode, and tracking the engine's done.
module matmul_tile_seq #(
   parameter int ADDR_W     = 10,
   parameter int STRIDE_W   = 8,
   parameter int DIM_W      = 4,
   parameter int TILE       = 4,
   parameter int CLR_CYCLES = 2
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 job_valid,
   output logic                 job_ready,
   input  logic [ADDR_W-1:0]    job_base_a,
   input  logic [ADDR_W-1:0]    job_base_b,
   input  logic [ADDR_W-1:0]    job_base_c,
   input  logic [DIM_W-1:0]     job_m,
   input  logic [DIM_W-1:0]     job_n,
   input  logic [DIM_W-1:0]     job_k,
   input  logic                 job_is_fp8,
   output logic                 busy,
   output logic                 job_done,
   output logic                 job_err,
   output logic [2*DIM_W-1:0]   tiles_done,
   output logic [ADDR_W-1:0]    mm_addr_a,
   output logic [ADDR_W-1:0]    mm_addr_b,
   output logic [ADDR_W-1:0]    mm_addr_c,
   output logic [STRIDE_W-1:0]  mm_stride_a,
   output logic [STRIDE_W-1:0]  mm_stride_b,
   output logic [STRIDE_W-1:0]  mm_stride_c,
   output logic                 mm_is_fp8,
   output logic                 mm_pe_resetn,
   output logic                 mm_start,
   input  logic                 mm_done
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLR,
      S_RUN,
      S_DRAIN,
      S_NEXT,
      S_FIN
   } state_t;

   localparam int CLR_W = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
   localparam logic [ADDR_W-1:0] TILE_INC = ADDR_W'(TILE);
   localparam logic [CLR_W-1:0]  CLR_LAST = CLR_W'(CLR_CYCLES - 1);

   state_t state_reg, state_next;

   logic [CLR_W-1:0]     clr_cnt_reg;
   logic [DIM_W-1:0]     m_reg, n_reg, k_reg;
   logic [DIM_W-1:0]     i_reg, j_reg, kk_reg;
   logic [ADDR_W-1:0]    addr_a_reg, addr_b_reg, addr_c_reg;
   logic [ADDR_W-1:0]    row_a_reg, base_b_reg;
   logic                 fp8_reg, err_reg, armed_reg;
   logic [2*DIM_W-1:0]   tiles_reg;

   logic accept, zero_dim, clr_last, k_last, j_last, i_last;

   assign accept   = job_valid && (state_reg == S_IDLE);
   assign zero_dim = (job_m == '0) || (job_n == '0) || (job_k == '0);
   assign clr_last = (clr_cnt_reg == CLR_LAST);
   assign k_last   = (kk_reg == k_reg - 1'b1);
   assign j_last   = (j_reg == n_reg - 1'b1);
   assign i_last   = (i_reg == m_reg - 1'b1);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_reg <= S_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE:  if (accept) state_next = zero_dim ? S_FIN : S_CLR;
         S_CLR:   if (clr_last) state_next = S_RUN;
         S_RUN:   if (mm_done) state_next = S_DRAIN;
         S_DRAIN: if (!mm_done) state_next = S_NEXT;
         S_NEXT: begin
            if (!k_last)                state_next = S_RUN;
            else if (i_last && j_last)  state_next = S_FIN;
            else                        state_next = S_CLR;
         end
         S_FIN:   state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   // Addresses advance with running adders only. At the end of a row of j tiles the
   // next A row starts exactly one tile past the last A tile just used.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         clr_cnt_reg <= '0;
         m_reg       <= '0;
         n_reg       <= '0;
         k_reg       <= '0;
         i_reg       <= '0;
         j_reg       <= '0;
         kk_reg      <= '0;
         addr_a_reg  <= '0;
         addr_b_reg  <= '0;
         addr_c_reg  <= '0;
         row_a_reg   <= '0;
         base_b_reg  <= '0;
         fp8_reg     <= 1'b0;
         err_reg     <= 1'b0;
         armed_reg   <= 1'b0;
         tiles_reg   <= '0;
      end else begin
         if (state_reg == S_CLR && !clr_last) begin
            clr_cnt_reg <= clr_cnt_reg + 1'b1;
         end else begin
            clr_cnt_reg <= '0;
         end

         if (accept) begin
            m_reg      <= job_m;
            n_reg      <= job_n;
            k_reg      <= job_k;
            i_reg      <= '0;
            j_reg      <= '0;
            kk_reg     <= '0;
            addr_a_reg <= job_base_a;
            row_a_reg  <= job_base_a;
            addr_b_reg <= job_base_b;
            base_b_reg <= job_base_b;
            addr_c_reg <= job_base_c;
            fp8_reg    <= job_is_fp8;
            err_reg    <= zero_dim;
            armed_reg  <= 1'b1;
            tiles_reg  <= '0;
         end else if (state_reg == S_NEXT) begin
            if (!k_last) begin
               kk_reg     <= kk_reg + 1'b1;
               addr_a_reg <= addr_a_reg + TILE_INC;
               addr_b_reg <= addr_b_reg + TILE_INC;
            end else begin
               tiles_reg <= tiles_reg + 1'b1;
               if (!(i_last && j_last)) begin
                  kk_reg     <= '0;
                  addr_c_reg <= addr_c_reg + TILE_INC;
                  if (j_last) begin
                     j_reg      <= '0;
                     i_reg      <= i_reg + 1'b1;
                     addr_a_reg <= addr_a_reg + TILE_INC;
                     row_a_reg  <= addr_a_reg + TILE_INC;
                     addr_b_reg <= base_b_reg;
                  end else begin
                     j_reg      <= j_reg + 1'b1;
                     addr_a_reg <= row_a_reg;
                     addr_b_reg <= addr_b_reg + TILE_INC;
                  end
               end
            end
         end
      end
   end

   assign job_ready    = (state_reg == S_IDLE);
   assign busy         = (state_reg != S_IDLE) && (state_reg != S_FIN);
   assign job_done     = (state_reg == S_FIN);
   assign job_err      = err_reg;
   assign tiles_done   = tiles_reg;
   assign mm_start     = (state_reg == S_RUN);
   // PEs stay cleared from reset until the first job arrives.
   assign mm_pe_resetn = armed_reg && (state_reg != S_CLR);
   assign mm_is_fp8    = fp8_reg;
   assign mm_addr_a    = addr_a_reg;
   assign mm_addr_b    = addr_b_reg;
   assign mm_addr_c    = addr_c_reg;
   assign mm_stride_a  = STRIDE_W'(1);
   assign mm_stride_b  = STRIDE_W'(1);
   assign mm_stride_c  = STRIDE_W'(1);

endmodule

// File: tb/tb_matmul_tile_seq.sv
// Bench for matmul_tile_seq: behavioural engine stub plus a loop-nest reference model of the
// expected tile passes, driven by a job table and hand-written reset / back-to-back sequences.
module tb_matmul_tile_seq;

   localparam int ADDR_W     = 10;
   localparam int STRIDE_W   = 8;
   localparam int DIM_W      = 4;
   localparam int TILE       = 4;
   localparam int CLR_CYCLES = 2;

   logic                clk = 1'b0;
   logic                resetn = 1'b0;
   logic                job_valid = 1'b0;
   logic                job_ready;
   logic [ADDR_W-1:0]   job_base_a = '0, job_base_b = '0, job_base_c = '0;
   logic [DIM_W-1:0]    job_m = '0, job_n = '0, job_k = '0;
   logic                job_is_fp8 = 1'b0;
   logic                busy, job_done, job_err;
   logic [2*DIM_W-1:0]  tiles_done;
   logic [ADDR_W-1:0]   mm_addr_a, mm_addr_b, mm_addr_c;
   logic [STRIDE_W-1:0] mm_stride_a, mm_stride_b, mm_stride_c;
   logic                mm_is_fp8, mm_pe_resetn, mm_start;
   logic                mm_done = 1'b0;

   always #5 clk = ~clk;

   matmul_tile_seq #(
      .ADDR_W(ADDR_W), .STRIDE_W(STRIDE_W), .DIM_W(DIM_W), .TILE(TILE), .CLR_CYCLES(CLR_CYCLES)
   ) dut (
      .clk(clk), .resetn(resetn),
      .job_valid(job_valid), .job_ready(job_ready),
      .job_base_a(job_base_a), .job_base_b(job_base_b), .job_base_c(job_base_c),
      .job_m(job_m), .job_n(job_n), .job_k(job_k), .job_is_fp8(job_is_fp8),
      .busy(busy), .job_done(job_done), .job_err(job_err), .tiles_done(tiles_done),
      .mm_addr_a(mm_addr_a), .mm_addr_b(mm_addr_b), .mm_addr_c(mm_addr_c),
      .mm_stride_a(mm_stride_a), .mm_stride_b(mm_stride_b), .mm_stride_c(mm_stride_c),
      .mm_is_fp8(mm_is_fp8), .mm_pe_resetn(mm_pe_resetn), .mm_start(mm_start), .mm_done(mm_done)
   );

   typedef struct {
      logic [ADDR_W-1:0] ba, bb, bc;
      int                m, n, k;
      logic              fp8;
      int                lat, hold;
      int                exp_tiles;
      logic              exp_err;
   } job_t;

   typedef struct {
      logic [ADDR_W-1:0] a, b, c;
      logic              fp8;
   } pass_t;

   int    checks = 0;
   int    errors = 0;
   pass_t obs_q[$];
   pass_t exp_q[$];
   pass_t p_obs;
   int    clr_cycles = 0;
   int    eng_lat = 20, eng_hold = 1;
   int    eng_cnt = 0, eng_left = 0;
   logic  prev_start = 1'b0;

   task automatic chk(input string name, input int unsigned act, input int unsigned exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Engine stub: a rising start launches a pass; done rises eng_lat cycles later and stays
   // high for eng_hold cycles. Every launch is logged with the addresses presented.
   always @(negedge clk) begin
      if (!resetn) begin
         mm_done    = 1'b0;
         eng_cnt    = 0;
         eng_left   = 0;
         prev_start = 1'b0;
      end else begin
         if (busy && !mm_pe_resetn) clr_cycles++;
         if (mm_start && !prev_start) begin
            p_obs.a   = mm_addr_a;
            p_obs.b   = mm_addr_b;
            p_obs.c   = mm_addr_c;
            p_obs.fp8 = mm_is_fp8;
            obs_q.push_back(p_obs);
            chk("start_vs_done", mm_done, 0);
            chk("pe_active_at_start", mm_pe_resetn, 1);
            eng_cnt = eng_lat;
         end
         if (mm_done) begin
            eng_left--;
            if (eng_left <= 0) mm_done = 1'b0;
         end else if (eng_cnt > 0) begin
            eng_cnt--;
            if (eng_cnt == 0) begin
               mm_done  = 1'b1;
               eng_left = eng_hold;
            end
         end
         prev_start = mm_start;
      end
   end

   // Reference: the full i/j/k loop nest with the tile layout formulas, modulo 2^ADDR_W.
   task automatic model(input job_t jb);
      pass_t p;
      exp_q.delete();
      for (int i = 0; i < jb.m; i++)
         for (int j = 0; j < jb.n; j++)
            for (int kk = 0; kk < jb.k; kk++) begin
               p.a   = ADDR_W'((int'(jb.ba) + (i * jb.k + kk) * TILE) % (1 << ADDR_W));
               p.b   = ADDR_W'((int'(jb.bb) + (j * jb.k + kk) * TILE) % (1 << ADDR_W));
               p.c   = ADDR_W'((int'(jb.bc) + (i * jb.n + j) * TILE) % (1 << ADDR_W));
               p.fp8 = jb.fp8;
               exp_q.push_back(p);
            end
   endtask

   task automatic drive_fields(input job_t jb);
      job_base_a = jb.ba;
      job_base_b = jb.bb;
      job_base_c = jb.bc;
      job_m      = DIM_W'(jb.m);
      job_n      = DIM_W'(jb.n);
      job_k      = DIM_W'(jb.k);
      job_is_fp8 = jb.fp8;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_job_ready"}, job_ready, 1);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_job_done"}, job_done, 0);
      chk({tag, "_job_err"}, job_err, 0);
      chk({tag, "_tiles_done"}, tiles_done, 0);
      chk({tag, "_mm_start"}, mm_start, 0);
      chk({tag, "_pe_resetn"}, mm_pe_resetn, 0);
      chk({tag, "_is_fp8"}, mm_is_fp8, 0);
      chk({tag, "_addrs"}, {mm_addr_a, mm_addr_b, mm_addr_c}, 0);
      chk({tag, "_strides"}, {mm_stride_a, mm_stride_b, mm_stride_c}, 24'h010101);
   endtask

   // Waits at negedges for job_done; returns cycles waited (bounded).
   task automatic wait_done(output int cyc);
      cyc = 1;
      while (!job_done && cyc < 20000) begin
         @(negedge clk);
         cyc++;
      end
      chk("job_done_seen", job_done, 1);
   endtask

   task automatic compare_passes(input string tag);
      chk({tag, "_pass_count"}, obs_q.size(), exp_q.size());
      for (int p = 0; p < exp_q.size(); p++) begin
         if (p < obs_q.size())
            chk({tag, "_pass"}, {obs_q[p].a, obs_q[p].b, obs_q[p].c, obs_q[p].fp8},
                {exp_q[p].a, exp_q[p].b, exp_q[p].c, exp_q[p].fp8});
      end
   endtask

   task automatic run_job(input job_t jb, input int idx);
      int n;
      int cyc;
      model(jb);
      obs_q.delete();
      clr_cycles = 0;
      eng_lat    = jb.lat;
      eng_hold   = jb.hold;
      @(negedge clk);
      drive_fields(jb);
      job_valid = 1'b1;
      n = 0;
      while (!job_ready && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk("ready_before_accept", job_ready, 1);
      @(negedge clk);
      job_valid = 1'b0;
      wait_done(cyc);
      if (jb.exp_err) chk("zero_dim_done_latency", (cyc <= 3), 1);
      chk("tiles_done", tiles_done, jb.exp_tiles);
      chk("job_err", job_err, jb.exp_err);
      chk("busy_in_fin", busy, 0);
      chk("ready_in_fin", job_ready, 0);
      chk("clr_cycles", clr_cycles, CLR_CYCLES * jb.exp_tiles);
      compare_passes("job");
      @(negedge clk);
      chk("ready_after_fin", job_ready, 1);
      chk("job_done_one_cycle", job_done, 0);
      chk("pe_resetn_idle", mm_pe_resetn, 1);
      chk("tiles_done_hold", tiles_done, jb.exp_tiles);
      $display("job %0d: M=%0d N=%0d K=%0d fp8=%0d lat=%0d hold=%0d passes=%0d tiles=%0d err=%0d cycles=%0d",
               idx, jb.m, jb.n, jb.k, jb.fp8, jb.lat, jb.hold, obs_q.size(), tiles_done, job_err, cyc);
   endtask

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      job_t vec[11];
      job_t garbage, j1, j2;
      int   n, cyc;
      logic seen_done;

      vec[0] = '{ba:10'h000, bb:10'h000, bc:10'h000, m:1, n:1, k:1, fp8:1'b0, lat:20, hold:1, exp_tiles:1, exp_err:1'b0};
      vec[1] = '{ba:10'h000, bb:10'h040, bc:10'h080, m:2, n:2, k:2, fp8:1'b1, lat:6,  hold:1, exp_tiles:4, exp_err:1'b0};
      vec[2] = '{ba:10'h010, bb:10'h020, bc:10'h030, m:1, n:2, k:2, fp8:1'b0, lat:3,  hold:5, exp_tiles:2, exp_err:1'b0};
      vec[3] = '{ba:10'h005, bb:10'h006, bc:10'h007, m:2, n:2, k:0, fp8:1'b1, lat:3,  hold:1, exp_tiles:0, exp_err:1'b1};
      vec[4] = '{ba:10'h3F8, bb:10'h3FC, bc:10'h3FE, m:2, n:1, k:3, fp8:1'b0, lat:2,  hold:2, exp_tiles:2, exp_err:1'b0};
      for (int r = 5; r < 11; r++) begin
         vec[r].ba   = ADDR_W'($urandom);
         vec[r].bb   = ADDR_W'($urandom);
         vec[r].bc   = ADDR_W'($urandom);
         vec[r].m    = $urandom_range(0, 3);
         vec[r].n    = $urandom_range(0, 3);
         vec[r].k    = $urandom_range(0, 3);
         vec[r].fp8  = 1'($urandom);
         vec[r].lat  = $urandom_range(1, 5);
         vec[r].hold = $urandom_range(1, 4);
         vec[r].exp_err   = (vec[r].m == 0) || (vec[r].n == 0) || (vec[r].k == 0);
         vec[r].exp_tiles = vec[r].exp_err ? 0 : vec[r].m * vec[r].n;
      end

      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      resetn = 1'b1;
      @(negedge clk);
      chk("idle_pe_resetn_before_first_job", mm_pe_resetn, 0);

      for (int r = 0; r < 11; r++) begin
         run_job(vec[r], r);
         if (r == 1) begin
            chk("t2_last_pass", {obs_q[obs_q.size()-1].a, obs_q[obs_q.size()-1].b, obs_q[obs_q.size()-1].c},
                {10'h00C, 10'h04C, 10'h08C});
         end
      end

      // Reset in the RUN of the third pass of the 2x2x2 job.
      obs_q.delete();
      eng_lat  = 6;
      eng_hold = 1;
      @(negedge clk);
      drive_fields(vec[1]);
      job_valid = 1'b1;
      n = 0;
      while (!job_ready && n < 2000) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      job_valid = 1'b0;
      n = 0;
      while (obs_q.size() < 3 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk("midjob_in_run", mm_start, 1);
      resetn = 1'b0;
      #1;
      check_reset_outputs("async_reset");
      seen_done = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         if (job_done) seen_done = 1'b1;
      end
      chk("no_done_after_reset", seen_done, 0);
      resetn = 1'b1;
      $display("reset mid-job: passes_before_reset=%0d", obs_q.size());
      run_job(vec[0], 100);

      // Back-to-back: second descriptor held (and edited) while the first job runs.
      j1 = '{ba:10'h000, bb:10'h000, bc:10'h000, m:1, n:2, k:1, fp8:1'b0, lat:4, hold:1, exp_tiles:2, exp_err:1'b0};
      j2 = '{ba:10'h100, bb:10'h200, bc:10'h300, m:1, n:1, k:2, fp8:1'b1, lat:3, hold:2, exp_tiles:1, exp_err:1'b0};
      garbage = '{ba:10'h3AA, bb:10'h155, bc:10'h2F0, m:3, n:3, k:3, fp8:1'b0, lat:0, hold:0, exp_tiles:0, exp_err:1'b0};
      eng_lat  = j1.lat;
      eng_hold = j1.hold;
      @(negedge clk);
      drive_fields(j1);
      job_valid = 1'b1;
      n = 0;
      while (!job_ready && n < 2000) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      drive_fields(garbage);
      repeat (5) @(negedge clk);
      drive_fields(j2);
      wait_done(cyc);
      chk("b2b_job1_tiles", tiles_done, 2);
      model(j2);
      obs_q.delete();
      clr_cycles = 0;
      eng_lat  = j2.lat;
      eng_hold = j2.hold;
      @(negedge clk);
      chk("b2b_ready_after_done", job_ready, 1);
      @(negedge clk);
      chk("b2b_accepted_busy", busy, 1);
      chk("b2b_accepted_not_ready", job_ready, 0);
      drive_fields(garbage);
      job_valid = 1'b0;
      wait_done(cyc);
      chk("b2b_job2_tiles", tiles_done, 1);
      chk("b2b_job2_err", job_err, 0);
      compare_passes("b2b");
      $display("back-to-back: job2 passes=%0d tiles=%0d cycles=%0d", obs_q.size(), tiles_done, cyc);

      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
